// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair.
// An operation accepted from EX computes its result right away, parks it in
// a pending register, and commits it to HI/LO after a fixed busy period.
// That period mimics the latency of an iterative multiplier or divider.
// The stall request keeps any HI/LO-related instruction in ID from
// advancing while that result is still outstanding.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        md_use_ID,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_md
);

  // Sequencer states.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // Operation encodings from EX.
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Counter reload values for each latency class.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [31:0]      pending_hi;
  logic [31:0]      pending_lo;
  logic             pending_wr;

  // Decoded operation class.
  logic is_mul;
  logic is_div;
  logic is_long;
  logic issue;

  // Multiplier datapath.
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  // Divider datapath.
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quotient;
  logic [31:0] remainder;

  // Result selected for the pending register.
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        result_wr;

  // Decode the EX operation; only mult/div class ops enter the busy period.
  always_comb begin
    is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
    is_div  = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    is_long = is_mul || is_div;
    issue   = start && is_long && (state == IDLE);
  end

  // One 64x64 multiplier: sign- or zero-extending the operands makes the low
  // 64 bits of the product correct for both mult and multu.
  always_comb begin
    mul_signed = (md_op == OP_MULT);
    mul_a      = {{32{mul_signed & operand_a[31]}}, operand_a};
    mul_b      = {{32{mul_signed & operand_b[31]}}, operand_b};
    product    = mul_a * mul_b;
  end

  // Signed division runs on magnitudes, then fixes signs: the quotient is
  // negative when the operand signs differ, and the remainder follows the
  // dividend. 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
  always_comb begin
    div_signed = (md_op == OP_DIV);
    a_neg      = div_signed & operand_a[31];
    b_neg      = div_signed & operand_b[31];
    b_zero     = (operand_b == 32'd0);
    a_mag      = a_neg ? (32'd0 - operand_a) : operand_a;
    b_mag      = b_neg ? (32'd0 - operand_b) : operand_b;
    divisor    = b_zero ? 32'd1 : b_mag;
    q_mag      = a_mag / divisor;
    r_mag      = a_mag % divisor;
    quotient   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    remainder  = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  // Choose what to park. A divide by zero still occupies the unit for the
  // full period but leaves HI/LO alone at commit.
  always_comb begin
    result_hi = 32'd0;
    result_lo = 32'd0;
    result_wr = 1'b0;
    if (is_mul) begin
      result_hi = product[63:32];
      result_lo = product[31:0];
      result_wr = 1'b1;
    end else if (is_div) begin
      result_hi = remainder;
      result_lo = quotient;
      result_wr = !b_zero;
    end
  end

  // Sequencer: accept ops in IDLE, count down in BUSY, commit on the last
  // busy edge so the new HI/LO appear in the same cycle busy drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      pending_wr <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            pending_hi <= result_hi;
            pending_lo <= result_lo;
            pending_wr <= result_wr;
            count      <= is_mul ? MULT_LOAD : DIV_LOAD;
            state      <= BUSY;
          end else if (start && (md_op == OP_MTHI)) begin
            hi <= operand_a;
          end else if (start && (md_op == OP_MTLO)) begin
            lo <= operand_a;
          end
        end
        BUSY: begin
          // New starts are ignored here; the hazard stall keeps them away.
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            if (pending_wr) begin
              hi <= pending_hi;
              lo <= pending_lo;
            end
            pending_wr <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // busy is purely a function of the registered state.
  assign busy = (state == BUSY);

  // Stall an HI/LO consumer in ID during the issue cycle and every busy
  // cycle. mthi/mtlo need no stall: they write at the edge where ID advances.
  assign stall_md = md_use_ID & (busy | (start & is_long));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: directed tests for the multiply/divide sequencer.
// A cycle-level reference model computes results with wide integer
// arithmetic, and a negedge process compares hi/lo/busy/stall_md against it
// every cycle. Literal expectations pin selected results and latencies.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] operand_a = 32'd0;
  logic [31:0] operand_b = 32'd0;
  logic        md_use_ID = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .operand_a(operand_a), .operand_b(operand_b), .md_use_ID(md_use_ID),
    .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_remain = 0;
  logic [31:0] m_pend_hi = 32'd0;
  logic [31:0] m_pend_lo = 32'd0;
  bit          m_pend_wr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: results from plain 64-bit integer arithmetic, latency
  // as a remaining-cycle count.
  always @(posedge clk) begin
    longint sa, sb, sq, sr;
    logic [63:0] up;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_remain = 0; m_pend_wr = 0;
    end else if (m_remain > 0) begin
      m_remain--;
      if (m_remain == 0 && m_pend_wr) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end else if (start) begin
      sa = longint'($signed(operand_a));
      sb = longint'($signed(operand_b));
      case (md_op)
        3'd1: begin
          sq = sa * sb;
          {m_pend_hi, m_pend_lo} = sq[63:0];
          m_pend_wr = 1; m_remain = 5;
        end
        3'd2: begin
          up = 64'(operand_a) * 64'(operand_b);
          {m_pend_hi, m_pend_lo} = up;
          m_pend_wr = 1; m_remain = 5;
        end
        3'd3: begin
          m_pend_wr = (operand_b != 0); m_remain = 10;
          if (operand_b != 0) begin
            sq = sa / sb; sr = sa % sb;
            m_pend_lo = sq[31:0]; m_pend_hi = sr[31:0];
          end
        end
        3'd4: begin
          m_pend_wr = (operand_b != 0); m_remain = 10;
          if (operand_b != 0) begin
            m_pend_lo = operand_a / operand_b;
            m_pend_hi = operand_a % operand_b;
          end
        end
        3'd5: m_hi = operand_a;
        3'd6: m_lo = operand_a;
        default: ;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic exp_stall;
    if (chk_en) begin
      exp_stall = md_use_ID & ((m_remain != 0) | (start & (md_op >= 3'd1) & (md_op <= 3'd4)));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      check("cyc_busy", {31'd0, busy}, {31'd0, (m_remain != 0)});
      check("cyc_stall", {31'd0, stall_md}, {31'd0, exp_stall});
    end
  end

  // Present an op for one cycle starting just after an edge; the op is
  // accepted at the following edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall, input string name);
    start = 1'b1; md_op = op; operand_a = a; operand_b = b;
    #1;
    check({name, "_issue_stall"}, {31'd0, stall_md}, {31'd0, exp_stall});
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    $display("issue %s op=%0d a=0x%08h b=0x%08h", name, op, a, b);
  endtask

  // Count busy cycles until completion, bounded.
  task automatic wait_done(input int exp_n, input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_n));
    $display("done  %s busy_cycles=%0d hi=0x%08h lo=0x%08h", name, n, hi, lo);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Signed multiply with stall generation.
    md_use_ID = 1'b1;
    issue(3'd1, 32'd3, 32'hFFFF_FFFE, 1'b1, "mult");
    wait_done(5, "mult");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("mult_stall_after", {31'd0, stall_md}, 32'd0);

    // Signed and unsigned divide without an ID consumer.
    md_use_ID = 1'b0;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
    wait_done(10, "div");
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "divu");
    wait_done(10, "divu");
    check("divu_lo", lo, 32'h7FFF_FFFC);
    check("divu_hi", hi, 32'd1);

    // mthi/mtlo preload, then divide by zero leaves them intact.
    md_use_ID = 1'b1;
    issue(3'd5, 32'h11, 32'd0, 1'b0, "mthi");
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(3'd6, 32'h22, 32'd0, 1'b0, "mtlo");
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    md_use_ID = 1'b0;
    issue(3'd4, 32'h1234, 32'd0, 1'b0, "divu0");
    wait_done(10, "divu0");
    check("divu0_hi", hi, 32'h11);
    check("divu0_lo", lo, 32'h22);

    // Signed division overflow.
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "divovf");
    wait_done(10, "divovf");
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // Reset during busy cycle 3 of a divide aborts it.
    issue(3'd3, 32'd100, 32'd7, 1'b0, "div_abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    $display("reset mid-op busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);
    issue(3'd1, 32'd7, 32'd6, 1'b0, "mult_after_reset");
    wait_done(5, "mult_after_reset");
    check("mult_after_reset_lo", lo, 32'd42);
    check("mult_after_reset_hi", hi, 32'd0);

    // Back-to-back ops, plus a start while busy that must be ignored.
    md_use_ID = 1'b1;
    issue(3'd1, 32'd2, 32'd3, 1'b1, "mult_b2b");
    wait_done(5, "mult_b2b");
    check("mult_b2b_lo", lo, 32'd6);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "multu_b2b");
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd3; operand_a = 32'd5; operand_b = 32'd1;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'd0;
    $display("start while busy ignored busy=%0d", busy);
    wait_done(3, "multu_b2b");
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_stall_after", {31'd0, stall_md}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_ignored_start", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
